reg_wb_sched: RTL and testbench
===============================

# reg_wb_sched

Write-back scheduler for the 16-entry register file (r15 = PC). Shares the register file's single write port between the ALU result path and the load-data path, buffers ALU results that lose arbitration in a small in-order FIFO, and preserves same-register write order. Drives the register file's `we`/`wa`/`wd` inputs and exports a pending-write mask that decode uses for hazard stalls.

## Interface
Parameters:
- ADDR_WIDTH, 4, register address width; `1<<ADDR_WIDTH` registers, last one is PC
- DEPTH, 2, ALU skid FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  clock, all state on posedge
- reset  input  1  asynchronous, active-low; clears all state
- alu_valid  input  1  ALU write-back request
- alu_wa  input  ADDR_WIDTH  ALU destination register
- alu_wd  input  `FULLW  ALU result
- alu_ready  output  1  ALU request accepted this cycle when high with alu_valid
- ld_valid  input  1  load write-back request
- ld_wa  input  ADDR_WIDTH  load destination register
- ld_wd  input  `FULLW  load data
- ld_ready  output  1  load accepted this cycle when high with ld_valid
- we  output  1  register file write enable (registered)
- wa  output  ADDR_WIDTH  register file write address (registered)
- wd  output  `FULLW  register file write data (registered)
- pend_mask  output  1<<ADDR_WIDTH  bit n set while any buffered or issuing write targets register n

## Operation
- Per cycle at most one write is selected for issue; selection priority:
  1. Load, if ld_valid and ld_wa matches no valid FIFO entry.
  2. FIFO head, if FIFO non-empty.
  3. New ALU request, if alu_valid, alu_ready and FIFO empty.
- ld_ready = no FIFO entry has wa == ld_wa. A conflicting load waits; the FIFO keeps draining, so the wait is bounded by DEPTH cycles.
- alu_ready = (count < DEPTH), from registered count only.
- An accepted ALU request that is not issued directly is pushed to the FIFO tail. This covers the cases where the load won or the FIFO was non-empty.
- Push and pop may occur in the same cycle. count is updated by +1, -1 or 0.
- A same-cycle load and ALU request to the same register: the load writes first and the ALU write follows. The load is treated as older.
- Writes with wa == 15 pass through unchanged. PC redirect is the register file's concern.
- pend_mask = OR of one-hot(wa) over valid FIFO entries, plus one-hot(wa) when we=1.
- Pointers wrap modulo DEPTH. count width is clog2(DEPTH)+1.

## Timing
- Latency is 1 cycle from acceptance to we=1 on the issued write. Buffered writes issue in FIFO order, one per cycle, when no eligible load is present.
- Throughput is one register write per cycle.
- Reset values: we=0, wa=0, wd=0, count=0, head/tail=0, pend_mask=0. alu_ready=1 and ld_ready=1 during reset.
- Reset asserted mid-operation discards buffered writes immediately. No write is issued until the first posedge after deassertion.
- FIFO full: alu_ready=0. Loads are still accepted if non-conflicting, and the head still drains when no load is present.
- FIFO empty with no requests: we=0 next cycle. wa/wd hold their last values.

## Structure
- `FULLW and `WIDTH come from defines.v. Add `RF_PC_ADDR (15) there for the PC index; no new typedefs.
- Sub-module wb_fifo holds the DEPTH-entry storage of {wa, wd}, head/tail/count, and the per-entry address compare against ld_wa. reg_wb_sched holds arbitration, the output register and pend_mask.

## Test plan
- Reset, then single ALU write alu_wa=3, alu_wd=0x11 -> cycle+1: we=1, wa=3, wd=0x11; pend_mask bit3 high for that cycle only.
- Same cycle: ld_wa=5/0xAA and alu_wa=6/0xBB -> cycle+1 writes r5=0xAA, cycle+2 writes r6=0xBB; count peaks at 1.
- Continuous loads with 3 ALU requests -> alu_ready drops after 2 buffered entries. Once loads stop, buffered writes drain in order at one per cycle.
- FIFO holds r7=0x1, ld_valid ld_wa=7 data 0x2 -> ld_ready=0 until r7=0x1 issues; next cycle r7=0x2 issues; final r7=0x2.
- ALU write wa=15, wd=0x100 -> we=1, wa=15, wd=0x100 next cycle; pend_mask bit15 set.
- Assert reset with 2 entries buffered -> we=0 and pend_mask=0 immediately; no stale write after deassertion.

Source files
------------

// File: rtl/reg_wb_sched_pkg.sv
// reg_wb_sched_pkg: shared widths and register-file constants for write-back scheduling
package reg_wb_sched_pkg;
  localparam int FULLW = 32;
  localparam int RF_PC_ADDR = 15;
endpackage

// File: rtl/reg_wb_sched_if.sv
// reg_wb_sched_if: ALU/load write-back requests and register-file write port
interface reg_wb_sched_if import reg_wb_sched_pkg::*; #(parameter int ADDR_WIDTH = 4) ();
  logic alu_valid, alu_ready, ld_valid, ld_ready, we;
  logic [ADDR_WIDTH-1:0] alu_wa, ld_wa, wa;
  logic [FULLW-1:0] alu_wd, ld_wd, wd;
  logic [(1<<ADDR_WIDTH)-1:0] pend_mask;
  modport master (output alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd,
                  input alu_ready, ld_ready, we, wa, wd, pend_mask);
  modport slave (input alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd,
                 output alu_ready, ld_ready, we, wa, wd, pend_mask);
endinterface

// File: rtl/reg_wb_sched_wb_fifo.sv
// wb_fifo: in-order skid buffer of {wa, wd} with per-entry load address compare
module wb_fifo import reg_wb_sched_pkg::*; #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [ADDR_WIDTH-1:0] push_wa,
  input  logic [FULLW-1:0] push_wd,
  input  logic [ADDR_WIDTH-1:0] ld_wa,
  output logic empty,
  output logic full,
  output logic ld_hit,
  output logic [ADDR_WIDTH-1:0] head_wa,
  output logic [FULLW-1:0] head_wd,
  output logic [(1<<ADDR_WIDTH)-1:0] mask
);
  localparam int PW = $clog2(DEPTH);
  localparam int NR = 1 << ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] wa_q [DEPTH];
  logic [FULLW-1:0] wd_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0] count;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  always_ff @(posedge clk)
    if (push) begin
      wa_q[tail] <= push_wa;
      wd_q[tail] <= push_wd;
    end
  assign empty = count == '0;
  assign full = count == (PW+1)'(DEPTH);
  assign head_wa = wa_q[head];
  assign head_wd = wd_q[head];
  // an entry is live when its distance from head is below count
  always_comb begin
    ld_hit = 1'b0;
    mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if ({1'b0, PW'(i) - head} < count) begin
        mask = mask | (NR'(1) << wa_q[i]);
        ld_hit = ld_hit | (wa_q[i] == ld_wa);
      end
  end
endmodule

// File: rtl/reg_wb_sched.sv
// reg_wb_sched: arbitrates ALU and load write-backs onto the single register-file write port
module reg_wb_sched import reg_wb_sched_pkg::*; #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic reset,
  reg_wb_sched_if.slave bus
);
  localparam int NR = 1 << ADDR_WIDTH;
  logic empty, full, ld_hit, ld_go, alu_acc, direct, pop, push, issue;
  logic [ADDR_WIDTH-1:0] head_wa, nxt_wa, wa_q;
  logic [FULLW-1:0] head_wd, nxt_wd, wd_q;
  logic [NR-1:0] fifo_mask;
  logic we_q;
  wb_fifo #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .push_wa(bus.alu_wa), .push_wd(bus.alu_wd), .ld_wa(bus.ld_wa),
    .empty(empty), .full(full), .ld_hit(ld_hit),
    .head_wa(head_wa), .head_wd(head_wd), .mask(fifo_mask)
  );
  // a load never overtakes a buffered write to the same register
  always_comb begin
    ld_go = bus.ld_valid && !ld_hit;
    alu_acc = bus.alu_valid && !full;
    pop = !ld_go && !empty;
    direct = alu_acc && !ld_go && empty;
    push = alu_acc && !direct;
    issue = ld_go || pop || direct;
    nxt_wa = ld_go ? bus.ld_wa : pop ? head_wa : bus.alu_wa;
    nxt_wd = ld_go ? bus.ld_wd : pop ? head_wd : bus.alu_wd;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= issue;
      if (issue) begin
        wa_q <= nxt_wa;
        wd_q <= nxt_wd;
      end
    end
  assign bus.ld_ready = !ld_hit;
  assign bus.alu_ready = !full;
  assign bus.we = we_q;
  assign bus.wa = wa_q;
  assign bus.wd = wd_q;
  assign bus.pend_mask = fifo_mask | (we_q ? NR'(1) << wa_q : '0);
endmodule

// File: tb/tb_reg_wb_sched.sv
// tb_reg_wb_sched: scoreboard bench for write-back ordering, readiness and pending mask
module tb_reg_wb_sched;
  import reg_wb_sched_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  reg_wb_sched_if #(.ADDR_WIDTH(4)) bus ();
  reg_wb_sched #(.ADDR_WIDTH(4), .DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic [35:0] exp_q [$];
  logic [35:0] mon_e;
  logic [FULLW-1:0] rf [16];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic lv, input logic [3:0] lwa, input logic [31:0] lwd,
                       input logic av, input logic [3:0] awa, input logic [31:0] awd);
    bus.ld_valid = lv;
    bus.ld_wa = lwa;
    bus.ld_wd = lwd;
    bus.alu_valid = av;
    bus.alu_wa = awa;
    bus.alu_wd = awd;
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (bus.we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got r%0d=%0h expected none", bus.wa, bus.wd);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_order", {bus.wa, bus.wd}, {28'd0, mon_e});
      end
      rf[bus.wa] = bus.wd;
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  int rdy_tab [6] = '{1, 1, 0, 0, 0, 1};
  logic [3:0] alu_tab [6] = '{4'd8, 4'd9, 4'd10, 4'd10, 4'd10, 4'd10};
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    foreach (rf[i]) rf[i] = '0;
    @(negedge clk);
    chk("rst_we", bus.we, 0);
    chk("rst_wa", bus.wa, 0);
    chk("rst_wd", bus.wd, 0);
    chk("rst_mask", bus.pend_mask, 0);
    chk("rst_alu_ready", bus.alu_ready, 1);
    chk("rst_ld_ready", bus.ld_ready, 1);
    reset = 1'b1;
    cyc();
    // single ALU write issues one cycle after acceptance
    exp_q.push_back({4'd3, 32'h11});
    drive(0, 0, 0, 1, 3, 32'h11);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("alu_mask", bus.pend_mask, 16'h0008);
    cyc();
    @(negedge clk);
    chk("idle_we", bus.we, 0);
    chk("idle_mask", bus.pend_mask, 0);
    chk("idle_wa_hold", bus.wa, 3);
    // same-cycle load and ALU: load first, ALU buffered
    exp_q.push_back({4'd5, 32'hAA});
    exp_q.push_back({4'd6, 32'hBB});
    drive(1, 5, 32'hAA, 1, 6, 32'hBB);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("dual_mask1", bus.pend_mask, 16'h0060);
    cyc();
    @(negedge clk);
    chk("dual_mask2", bus.pend_mask, 16'h0040);
    cyc();
    // continuous loads fill the FIFO; ALU stalls until drain
    for (int i = 1; i <= 4; i++) exp_q.push_back({4'(i), 32'h40 + 32'(i)});
    for (int i = 8; i <= 10; i++) exp_q.push_back({4'(i), 32'h78 + 32'(i)});
    for (int i = 0; i < 6; i++) begin
      drive(i < 4, 4'(i + 1), 32'h41 + 32'(i), 1, alu_tab[i], 32'h78 + 32'(alu_tab[i]));
      @(negedge clk);
      chk($sformatf("fill_alu_ready%0d", i), bus.alu_ready, 64'(rdy_tab[i]));
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    // conflicting load waits for buffered r7 to issue
    exp_q.push_back({4'd12, 32'h55});
    exp_q.push_back({4'd7, 32'h1});
    exp_q.push_back({4'd7, 32'h2});
    drive(1, 12, 32'h55, 1, 7, 32'h1);
    cyc();
    drive(1, 7, 32'h2, 0, 0, 0);
    @(negedge clk);
    chk("conflict_ld_ready", bus.ld_ready, 0);
    cyc();
    @(negedge clk);
    chk("released_ld_ready", bus.ld_ready, 1);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    // PC writes pass through unchanged
    exp_q.push_back({4'(RF_PC_ADDR), 32'h100});
    drive(0, 0, 0, 1, 4'(RF_PC_ADDR), 32'h100);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("pc_mask", bus.pend_mask, 16'h8000);
    repeat (2) cyc();
    // reset with two buffered entries discards them
    exp_q.push_back({4'd1, 32'h61});
    exp_q.push_back({4'd3, 32'h63});
    drive(1, 1, 32'h61, 1, 2, 32'h62);
    cyc();
    drive(1, 3, 32'h63, 1, 4, 32'h64);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("full_mask", bus.pend_mask, 16'h001C);
    chk("full_alu_ready", bus.alu_ready, 0);
    #1 reset = 1'b0;
    #1;
    chk("midrst_we", bus.we, 0);
    chk("midrst_mask", bus.pend_mask, 0);
    chk("midrst_alu_ready", bus.alu_ready, 1);
    chk("midrst_ld_ready", bus.ld_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    chk("post_rst_mask", bus.pend_mask, 0);
    chk("drained", 64'(exp_q.size()), 0);
    chk("r7_final", rf[7], 32'h2);
    chk("pc_final", rf[RF_PC_ADDR], 32'h100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
